// File: rtl/nco_poly_if.sv
// nco_poly_if: strobe, voice controls and mixed-sample outputs of the polyphonic NCO.
interface nco_poly_if #(
    parameter int VOICES = 4,
    parameter int SAMPLE_W = 8
);
    logic ce;
    logic [7*VOICES-1:0] note_num;
    logic [7*VOICES-1:0] note_vel;
    logic [VOICES-1:0] gate;
    logic [6:0] program_num;
    logic [SAMPLE_W-1:0] sample_out;
    logic sample_valid;
    logic busy;
    logic overrun;
    modport master (
        output ce, note_num, note_vel, gate, program_num,
        input sample_out, sample_valid, busy, overrun
    );
    modport slave (
        input ce, note_num, note_vel, gate, program_num,
        output sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/nco_poly.sv
// nco_poly: time-multiplexed polyphonic NCO, one voice per clock, mixed on each ce frame.
// Define NCO_POLY_RETRIG_EN to restart a voice's phase on a rising edge of its gate.
module nco_poly #(
    parameter int VOICES = 4,
    parameter int PHASE_W = 24,
    parameter int SAMPLE_W = 8,
    parameter int FS_HZ = 48000
) (
    input logic clk,
    input logic rst,
    nco_poly_if.slave bus
);
    localparam int LV = $clog2(VOICES);
    localparam int VW = (LV > 0) ? LV : 1;
    localparam int AW = SAMPLE_W + LV;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [VW-1:0] idx;
    logic [1:0] prog;
    logic [AW-1:0] acc;
    logic [PHASE_W-1:0] phase [VOICES];
    logic [PHASE_W-1:0] rom [16];
    // Top-octave increments (notes 120..131); lower octaves are right shifts of these.
    for (genvar s = 0; s < 16; s++) begin : g_rom
        localparam real R = (2.0 ** PHASE_W) * 440.0 * (2.0 ** ((51.0 + s) / 12.0)) / FS_HZ;
        assign rom[s] = (s < 12) ? PHASE_W'(longint'($floor(R + 0.5))) : '0;
    end
    logic [6:0] n;
    logic [6:0] vel;
    logic [3:0] oct;
    logic [3:0] semi;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] p;
    logic [SAMPLE_W-1:0] w;
    logic [SAMPLE_W-1:0] tri_w;
    logic [SAMPLE_W-1:0] shaped;
    logic [SAMPLE_W-1:0] scaled;
    logic [SAMPLE_W+6:0] prod;
    logic g;
    logic rise;
    logic unused_prog;
    assign unused_prog = ^bus.program_num[6:2];
    assign n = bus.note_num[7*idx +: 7];
    assign vel = bus.note_vel[7*idx +: 7];
    assign g = bus.gate[idx];
    assign oct = 4'(n / 7'd12);
    assign semi = 4'(n % 7'd12);
    assign inc = rom[semi] >> (4'd10 - oct);
`ifdef NCO_POLY_RETRIG_EN
    logic [VOICES-1:0] gate_hist;
    assign rise = g & ~gate_hist[idx];
`else
    assign rise = 1'b0;
`endif
    assign p = rise ? '0 : phase[idx];
    assign w = p[PHASE_W-1 -: SAMPLE_W];
    assign tri_w = w[SAMPLE_W-1] ? ~(w << 1) : (w << 1);
    always_comb shaped = (prog == 2'd0) ? {SAMPLE_W{w[SAMPLE_W-1]}} :
                         (prog == 2'd1) ? w :
                         (prog == 2'd2) ? tri_w : '0;
    assign prod = (SAMPLE_W+7)'(shaped) * (SAMPLE_W+7)'(vel);
    assign scaled = g ? SAMPLE_W'(prod >> 7) : '0;
    always_ff @(posedge clk) begin
        bus.sample_valid <= 1'b0;
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            prog <= '0;
            acc <= '0;
            bus.sample_out <= '0;
            bus.busy <= 1'b0;
            bus.overrun <= 1'b0;
            for (int i = 0; i < VOICES; i++) phase[i] <= '0;
`ifdef NCO_POLY_RETRIG_EN
            gate_hist <= '0;
`endif
        end else begin
            if (bus.ce && state != IDLE) bus.overrun <= 1'b1;
            if (state == IDLE && bus.ce) begin
                state <= RUN;
                prog <= bus.program_num[1:0];
                acc <= '0;
                idx <= '0;
                bus.busy <= 1'b1;
            end else if (state == RUN) begin
                acc <= acc + AW'(scaled);
                phase[idx] <= p + inc;
`ifdef NCO_POLY_RETRIG_EN
                gate_hist[idx] <= g;
`endif
                idx <= idx + 1'b1;
                if (idx == VW'(VOICES - 1)) state <= DONE;
            end else if (state == DONE) begin
                bus.sample_out <= SAMPLE_W'(acc >> LV);
                bus.sample_valid <= 1'b1;
                bus.busy <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_nco_poly.sv
// tb_nco_poly: randomized and directed checks of nco_poly against an arithmetic voice-mix model.
module tb_nco_poly;
    localparam int VOICES = 4;
    localparam int PHASE_W = 24;
    localparam int SAMPLE_W = 8;
    localparam int FS_HZ = 48000;
`ifdef NCO_POLY_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    nco_poly_if #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W)) bus ();
    nco_poly #(.VOICES(VOICES), .PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W), .FS_HZ(FS_HZ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    longint ph_m [VOICES];
    bit gh_m [VOICES];
    always @(negedge clk) if (bus.sample_valid === 1'b1) valid_cnt++;
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic longint inc_of(input int note);
        real r;
        longint top;
        r = (2.0 ** PHASE_W) * 440.0 * (2.0 ** ((120.0 + (note % 12) - 69.0) / 12.0)) / FS_HZ;
        top = longint'($floor(r + 0.5));
        return top >> (10 - note / 12);
    endfunction
    function automatic void model_reset();
        for (int v = 0; v < VOICES; v++) begin
            ph_m[v] = 0;
            gh_m[v] = 1'b0;
        end
    endfunction
    // One frame of the reference: shape, scale and sum every voice, then advance phases.
    function automatic longint model_frame();
        longint acc, p, w, s, full, half;
        int note, vel, pr;
        bit g;
        full = (longint'(1) << SAMPLE_W) - 1;
        half = longint'(1) << (SAMPLE_W - 1);
        pr = int'(bus.program_num[1:0]);
        acc = 0;
        for (int v = 0; v < VOICES; v++) begin
            note = int'(bus.note_num[7*v +: 7]);
            vel = int'(bus.note_vel[7*v +: 7]);
            g = bus.gate[v];
            p = ph_m[v];
            if (RETRIG && g && !gh_m[v]) p = 0;
            w = p >> (PHASE_W - SAMPLE_W);
            if (pr == 0) s = (w >= half) ? full : 0;
            else if (pr == 1) s = w;
            else if (pr == 2) s = (w < half) ? (2 * w) % (full + 1) : full - (2 * w) % (full + 1);
            else s = 0;
            if (g) acc += (s * vel) / 128;
            ph_m[v] = (p + inc_of(note)) % (longint'(1) << PHASE_W);
            gh_m[v] = g;
        end
        return acc / VOICES;
    endfunction
    task automatic set_voice(input int v, input int note, input int vel, input bit g);
        bus.note_num[7*v +: 7] = 7'(note);
        bus.note_vel[7*v +: 7] = 7'(vel);
        bus.gate[v] = g;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask
    task automatic run_frame(input string tag);
        int lat;
        longint exp_out;
        exp_out = model_frame();
        @(negedge clk);
        bus.ce = 1'b1;
        @(posedge clk);
        #1 bus.ce = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        lat = 0;
        while (bus.sample_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, VOICES + 1);
        check({tag, "_out"}, bus.sample_out, exp_out);
        check({tag, "_idle"}, bus.busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, bus.sample_valid, 0);
    endtask
    initial begin
        int v0, guard;
        longint exp_out;
        bus.ce = 1'b0;
        bus.note_num = '0;
        bus.note_vel = '0;
        bus.gate = '0;
        bus.program_num = 7'd1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ce = ~bus.ce;
            check("rst_out", bus.sample_out, 0);
            check("rst_valid", bus.sample_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_ovr", bus.overrun, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.ce = 1'b0;
        v0 = valid_cnt;
        repeat (10) @(negedge clk);
        check("rst_no_valid", valid_cnt - v0, 0);
        check("rst_busy_after", bus.busy, 0);
        set_voice(0, 69, 127, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            run_frame("a440");
            check("a440_phase", dut.phase[0], (longint'(k) * 153791) % (longint'(1) << 24));
        end
        do_reset();
        bus.program_num = 7'd0;
        for (int v = 0; v < VOICES; v++) set_voice(v, 0, 127, 1'b1);
        run_frame("sq");
        check("sq_first", bus.sample_out, 0);
        guard = 0;
        while (ph_m[0] < (longint'(1) << (PHASE_W - 1)) && guard < 4000) begin
            run_frame("sq");
            guard++;
        end
        run_frame("sq_msb");
        check("sq_253", bus.sample_out, 253);
        do_reset();
        bus.program_num = 7'd1;
        set_voice(0, 81, 90, 1'b1);
        exp_out = model_frame();
        v0 = valid_cnt;
        @(negedge clk);
        bus.ce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.ce = 1'b0;
        repeat (15) @(negedge clk);
        check("ovr_one_valid", valid_cnt - v0, 1);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_out", bus.sample_out, exp_out);
        do_reset();
        check("ovr_cleared", bus.overrun, 0);
        exp_out = model_frame();
        v0 = valid_cnt;
        @(negedge clk);
        bus.ce = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0;
        repeat (4) @(negedge clk);
        bus.ce = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0;
        repeat (15) @(negedge clk);
        check("done_one_valid", valid_cnt - v0, 1);
        check("done_ovr", bus.overrun, 1);
        check("done_out", bus.sample_out, exp_out);
        run_frame("ovr_keep");
        check("ovr_sticky", bus.overrun, 1);
        do_reset();
        for (int v = 0; v < VOICES; v++) set_voice(v, 0, 0, 1'b0);
        set_voice(0, 60, 100, 1'b1);
        run_frame("rt1");
        set_voice(0, 60, 100, 1'b0);
        run_frame("rt0");
        set_voice(0, 60, 100, 1'b1);
        run_frame("rt2");
        check("retrig_model", dut.phase[0], ph_m[0]);
        check("retrig_phase", dut.phase[0], RETRIG ? inc_of(60) : 3 * inc_of(60));
        run_frame("ab_pre");
        v0 = valid_cnt;
        @(negedge clk);
        bus.ce = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_phase", dut.phase[0], 0);
        check("abort_out", bus.sample_out, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (12) @(negedge clk);
        check("abort_no_valid", valid_cnt - v0, 0);
        for (int f = 0; f < 40; f++) begin
            for (int v = 0; v < VOICES; v++)
                set_voice(v, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1'($urandom));
            bus.program_num = 7'($urandom);
            run_frame("rnd");
            check("rnd_ph0", dut.phase[0], ph_m[0]);
            check("rnd_ph3", dut.phase[3], ph_m[3]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("rnd_no_ovr", bus.overrun, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nco_poly.md
# nco_poly

Parametrised, time-multiplexed polyphonic NCO and the successor to the single-voice `nco`. It holds one phase accumulator per voice and converts each voice's MIDI note number to a phase increment. Each voice is shaped by a shared program waveform and scaled by its velocity. On every sample strobe the block sums all voices into one mixed unsigned sample, and it sits between the MIDI voice allocator and the output DAC/PWM stage.

## Interface
- `VOICES`, 4, number of voices; power of two, 1..16
- `PHASE_W`, 24, phase accumulator width in bits
- `SAMPLE_W`, 8, waveform and output sample width in bits; SAMPLE_W ≤ PHASE_W
- `FS_HZ`, 48000, sample rate used to build the increment ROM at elaboration
- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `ce` in 1 sample strobe; a one-cycle pulse starts a frame
- `note_num` in 7*VOICES voice v occupies bits [7v+6:7v]
- `note_vel` in 7*VOICES velocity per voice, same packing
- `gate` in VOICES voice v active when high
- `program` in 7 waveform select; only bits [1:0] are used: 0 square, 1 saw, 2 triangle, 3 silence
- `sample_out` out SAMPLE_W mixed sample, unsigned
- `sample_valid` out 1 one-cycle pulse when `sample_out` updates
- `busy` out 1 high while a frame is in progress
- `overrun` out 1 sticky flag, set when `ce` arrives while busy

## Operation
- Reset values: all phases 0, `sample_out`=0, `sample_valid`=0, `busy`=0, `overrun`=0, gate history 0, FSM IDLE.
- FSM states:
  - IDLE: `ce`=1 latches `program[1:0]`, clears the mix accumulator, sets `busy`, sets v=0, moves to RUN.
  - RUN: processes one voice per clock; after v=VOICES-1, moves to DONE.
  - DONE: registers the output, pulses `sample_valid`, clears `busy`, returns to IDLE.
- Increment for note n:
  - oct = n/12, semi = n%12.
  - inc = ROM[semi] >> (10-oct).
  - ROM[s] = round(2^PHASE_W · 440 · 2^((120+s-69)/12) / FS_HZ), computed with real arithmetic at elaboration.
- Per-voice slot, using phase p sampled before the update:
  - w is the top SAMPLE_W bits of p.
  - Saw: w.
  - Square: all-ones if MSB(w)=1, else 0.
  - Triangle: (w<<1) if MSB(w)=0, else ~(w<<1), truncated to SAMPLE_W.
  - Silence: 0.
- Scaling: scaled = (w_shaped · vel) >> 7. A voice with gate=0 contributes 0.
- Accumulator: width SAMPLE_W+log2(VOICES).
- Phase update: phase[v] ← phase[v] + inc, modulo 2^PHASE_W. The phase advances even when gate=0.
- Output: `sample_out` = accumulator >> log2(VOICES).
- `note_num`, `note_vel` and `gate` for voice v are read in voice v's slot; `program` is read only at frame start.
- `ce` while `busy` is ignored and sets `overrun`. `overrun` clears only on `rst`.
- `ce` in the DONE cycle counts as busy, so it is ignored and sets `overrun`.
- `rst` mid-frame aborts the frame: no `sample_valid`, and every output takes its reset value on the next edge.

## Timing
- `ce` sampled high at edge N:
  - `busy`=1 from after edge N.
  - Voice v is processed at edge N+1+v.
  - `sample_out` and `sample_valid` update at edge N+VOICES+1.
  - `busy`=0 after edge N+VOICES+1.
- Minimum `ce` spacing is VOICES+2 clocks.
- `sample_out` holds its value between frames.

## Configuration
- `NCO_POLY_RETRIG_EN` defined: a rising edge of `gate[v]` is detected against the gate history sampled in the previous slot of voice v. On that edge, the phase used in that slot is 0, and the stored phase becomes inc.
- `NCO_POLY_RETRIG_EN` undefined: phases free-run and gate edges have no effect on the phase.

## Test plan
- Reset:
  - Stimulus: hold `rst` for 2 clocks with `ce` pulsing.
  - Response: all outputs stay 0, and no `sample_valid` appears.
- Increment and latency (defaults):
  - Stimulus: voice 0 note 69, vel 127, gate 1, program saw.
  - Response: after frame k, phase[0] = k·153791 mod 2^24, and `sample_valid` fires exactly 5 clocks after `ce`.
- Square mix:
  - Stimulus: all 4 voices note 0, vel 127, gate 1, program square.
  - Response: the first frame gives `sample_out`=0; once phase MSB=1, `sample_out`=253.
- Overrun:
  - Stimulus: `ce` on two consecutive clocks.
  - Response: exactly one `sample_valid`, and `overrun`=1 persisting until `rst`.
- Retrigger:
  - Stimulus: voice 0 gate toggled 1→0→1 across frames.
  - Response with the macro: phase[0] resets to inc. Response without the macro: phase[0] continues.
- Abort:
  - Stimulus: `rst` asserted during the second clock of a frame.
  - Response: no `sample_valid`, and `busy`=0 and phases 0 after the next edge.
